// File: rtl/piso_frame_tx.sv
// piso_frame_tx: framed parallel-in serial-out transmitter with a one-word holding buffer.
// Frame on o_serial_out: start(0), data bits, optional even parity, stop(1); each bit held BIT_CYCLES clocks.
module piso_frame_tx #(
    parameter int MSB        = 8,
    parameter bit LSB_FIRST  = 1'b0,
    parameter bit PARITY_EN  = 1'b0,
    parameter int BIT_CYCLES = 1
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic [MSB-1:0] i_data_in,
    input  logic           i_in_valid,
    output logic           o_in_ready,
    output logic           o_serial_out,
    output logic           o_busy,
    output logic           o_tx_done
);
    localparam int BW = $clog2(MSB);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]     r_state, w_state_nxt;
    logic [MSB-1:0] r_shift, w_shift_nxt;
    logic [MSB-1:0] r_buf, w_load_word;
    logic           r_buf_full;
    logic [BW-1:0]  r_bit_cnt, w_bit_nxt, w_idx;
    logic [7:0]     r_cyc_cnt, w_cyc_nxt;
    logic           r_serial, r_busy, r_tx_done;
    logic           w_last_cyc, w_stop_end, w_free, w_accept, w_load;
    logic           w_bit_val, w_ser_nxt;

    assign o_in_ready   = !r_buf_full;
    assign o_serial_out = r_serial;
    assign o_busy       = r_busy;
    assign o_tx_done    = r_tx_done;

    assign w_last_cyc  = r_cyc_cnt == 8'(BIT_CYCLES - 1);
    assign w_stop_end  = (r_state == STOP) && w_last_cyc;
    assign w_free      = (r_state == IDLE) || (w_stop_end && !r_buf_full);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_load      = (w_accept && w_free) || (w_stop_end && r_buf_full);
    assign w_load_word = r_buf_full ? r_buf : i_data_in;

    // The line is registered from the next state, so it always matches r_state.
    assign w_idx     = LSB_FIRST ? w_bit_nxt : BW'(MSB - 1) - w_bit_nxt;
    assign w_bit_val = w_shift_nxt[w_idx];
    assign w_ser_nxt = (w_state_nxt == START)  ? 1'b0 :
                       (w_state_nxt == DATA)   ? w_bit_val :
                       (w_state_nxt == PARITY) ? ^w_shift_nxt : 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit_cnt;
        w_cyc_nxt   = (r_state == IDLE || w_last_cyc) ? '0 : r_cyc_cnt + 8'd1;
        case (r_state)
            IDLE: begin
                w_state_nxt = w_load ? START : IDLE;
                w_shift_nxt = w_load ? w_load_word : r_shift;
            end
            START: begin
                w_state_nxt = w_last_cyc ? DATA : START;
                w_bit_nxt   = w_last_cyc ? '0 : r_bit_cnt;
            end
            DATA: begin
                w_state_nxt = !w_last_cyc ? DATA :
                              (r_bit_cnt != BW'(MSB - 1)) ? DATA :
                              PARITY_EN ? PARITY : STOP;
                w_bit_nxt   = w_last_cyc ? r_bit_cnt + 1'b1 : r_bit_cnt;
            end
            PARITY: w_state_nxt = w_last_cyc ? STOP : PARITY;
            STOP: begin
                w_state_nxt = !w_last_cyc ? STOP : w_load ? START : IDLE;
                w_shift_nxt = (w_last_cyc && w_load) ? w_load_word : r_shift;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_bit_cnt  <= '0;
            r_cyc_cnt  <= '0;
            r_serial   <= 1'b1;
            r_busy     <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_cyc_cnt <= w_cyc_nxt;
            r_serial  <= w_ser_nxt;
            r_busy    <= w_state_nxt != IDLE;
            r_tx_done <= w_stop_end;
            if (w_accept && !w_free) begin
                r_buf      <= i_data_in;
                r_buf_full <= 1'b1;
            end else if (w_stop_end && r_buf_full) begin
                r_buf_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_piso_frame_tx.sv
// tb_piso_frame_tx: scoreboard bench for piso_frame_tx across three parameter sets.
// Stimulus queues hand-written frames; a monitor captures each frame on the line and checks it at tx_done.
module tb_piso_frame_tx;
    typedef struct {
        logic [63:0] bits;
        int          len;
        logic [7:0]  word;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] vld = '0;
    logic [2:0] rdy, ser, bsy, done;
    logic [7:0] din [3];

    int          vectors = 0;
    int          miscompares = 0;
    int          idle0 = 0;
    frame_t      exp_q [3][$];
    logic [63:0] mon_bits [3];
    int          mon_len [3];

    always #5 clk = ~clk;

    piso_frame_tx #(.MSB(8), .LSB_FIRST(1'b0), .PARITY_EN(1'b0), .BIT_CYCLES(1)) u0 (
        .i_clk(clk), .i_reset(rst), .i_data_in(din[0]), .i_in_valid(vld[0]),
        .o_in_ready(rdy[0]), .o_serial_out(ser[0]), .o_busy(bsy[0]), .o_tx_done(done[0]));
    piso_frame_tx #(.MSB(8), .LSB_FIRST(1'b0), .PARITY_EN(1'b1), .BIT_CYCLES(1)) u1 (
        .i_clk(clk), .i_reset(rst), .i_data_in(din[1]), .i_in_valid(vld[1]),
        .o_in_ready(rdy[1]), .o_serial_out(ser[1]), .o_busy(bsy[1]), .o_tx_done(done[1]));
    piso_frame_tx #(.MSB(8), .LSB_FIRST(1'b1), .PARITY_EN(1'b0), .BIT_CYCLES(4)) u2 (
        .i_clk(clk), .i_reset(rst), .i_data_in(din[2]), .i_in_valid(vld[2]),
        .o_in_ready(rdy[2]), .o_serial_out(ser[2]), .o_busy(bsy[2]), .o_tx_done(done[2]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Each character of s is one line bit in transmit order, held r cycles.
    function automatic frame_t from_str(input string s, input int r, input logic [7:0] w);
        frame_t f;
        f.bits = '0;
        f.len  = 0;
        f.word = w;
        for (int i = 0; i < s.len(); i++)
            for (int j = 0; j < r; j++) begin
                f.bits[f.len] = (s[i] == "1");
                f.len++;
            end
        return f;
    endfunction

    always @(negedge clk) begin : monitor
        frame_t     f;
        logic [7:0] rx;
        if (!rst && !bsy[0]) idle0++;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mon_len[k]  = 0;
                mon_bits[k] = '0;
            end else begin
                if (done[k]) begin
                    if (exp_q[k].size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_frame dut%0d: got frame of %0d cycles, want none", k, mon_len[k]);
                    end else begin
                        f = exp_q[k].pop_front();
                        chk($sformatf("frame_len_dut%0d_%02h", k, f.word), 64'(mon_len[k]), 64'(f.len));
                        chk($sformatf("frame_bits_dut%0d_%02h", k, f.word), mon_bits[k], f.bits);
                        if (k == 0 && mon_len[k] == 10) begin
                            rx = '0;
                            for (int i = 1; i <= 8; i++) rx = {rx[6:0], mon_bits[0][i]};
                            chk($sformatf("loopback_%02h", f.word), 64'(rx), 64'(f.word));
                        end
                    end
                    mon_len[k]  = 0;
                    mon_bits[k] = '0;
                end
                if (bsy[k] && mon_len[k] < 64) begin
                    mon_bits[k][mon_len[k]] = ser[k];
                    mon_len[k]++;
                end
            end
        end
    end

    task automatic send(input int k, input logic [7:0] w, input string s, input int r,
                        input bit hold, output int n);
        logic acc;
        exp_q[k].push_back(from_str(s, r, w));
        din[k] = w;
        vld[k] = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = rdy[k];
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout dut%0d: got no accept in %0d cycles, want accept", k, n);
        end
        if (!hold) vld[k] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'd0);
    endtask

    initial begin
        int   n, i0;
        logic any;
        for (int k = 0; k < 3; k++) din[k] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_serial_dut%0d", k), 64'(ser[k]), 64'd1);
            chk($sformatf("reset_busy_dut%0d", k), 64'(bsy[k]), 64'd0);
            chk($sformatf("reset_done_dut%0d", k), 64'(done[k]), 64'd0);
            chk($sformatf("reset_ready_dut%0d", k), 64'(rdy[k]), 64'd1);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(0, 8'hA5, "0101001011", 1, 1'b0, n);
        chk("a5_start_bit", 64'(ser[0]), 64'd0);
        chk("a5_busy_rise", 64'(bsy[0]), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("a5_done_pulse", 64'(done[0]), 64'd1);
        chk("a5_busy_fall", 64'(bsy[0]), 64'd0);
        @(posedge clk);
        #1;
        chk("a5_done_single", 64'(done[0]), 64'd0);

        send(0, 8'h3C, "0001111001", 1, 1'b1, n);
        chk("b2b_ready_after_load", 64'(rdy[0]), 64'd1);
        i0 = idle0;
        send(0, 8'hFF, "0111111111", 1, 1'b1, n);
        chk("b2b_buffer_accept_wait", 64'(n), 64'd1);
        chk("b2b_ready_full", 64'(rdy[0]), 64'd0);
        send(0, 8'h00, "0000000001", 1, 1'b0, n);
        chk("b2b_third_accept_wait", 64'(n), 64'd10);
        repeat (19) @(posedge clk);
        #1;
        chk("b2b_third_done", 64'(done[0]), 64'd1);
        chk("b2b_busy_gaps", 64'(idle0 - i0), 64'd0);

        send(1, 8'h07, "00000011111", 1, 1'b0, n);
        send(1, 8'h03, "00000001101", 1, 1'b0, n);
        send(2, 8'h01, "0100000001", 4, 1'b0, n);
        drain();

        send(0, 8'h96, "0", 1, 1'b0, n);
        send(0, 8'h55, "0", 1, 1'b0, n);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q[0].delete();
        @(posedge clk);
        #1;
        chk("abort_serial", 64'(ser[0]), 64'd1);
        chk("abort_busy", 64'(bsy[0]), 64'd0);
        chk("abort_ready", 64'(rdy[0]), 64'd1);
        chk("abort_done", 64'(done[0]), 64'd0);
        rst = 1'b0;
        any = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            any = any | done[0];
        end
        chk("abort_no_done", 64'(any), 64'd0);
        send(0, 8'hC3, "0110000111", 1, 1'b0, n);
        drain();

        send(0, 8'h00, "0000000001", 1, 1'b1, n);
        send(0, 8'hFF, "0111111111", 1, 1'b1, n);
        send(0, 8'h5A, "0010110101", 1, 1'b1, n);
        send(0, 8'h81, "0100000011", 1, 1'b0, n);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
